mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one memory port between the I-cache (read-only) and the D-cache (read/write) refill/writeback paths.
//  Sits between both caches' mem_req_* interfaces and the single backing memory.
//  Runs one transaction at a time: arbitrates, forwards the winner's request, and returns data plus a one-cycle ready pulse to the owner only.
// PARAMETERS
//  ADDR_W  32  address width, all ports
//  DATA_W  32  data width, all ports
// PORTS
//  clk            in   1       single clock, rising edge
//  rst            in   1       asynchronous reset, active-high
//  i_req_addr     in   ADDR_W  I-cache request address
//  i_req_valid    in   1       I-cache request; held high until i_req_ready
//  i_req_data     out  DATA_W  read data to I-cache, valid while i_req_ready=1
//  i_req_ready    out  1       one-cycle completion pulse to I-cache
//  d_req_addr     in   ADDR_W  D-cache request address
//  d_req_valid    in   1       D-cache request; held high until d_req_ready
//  d_req_wr       in   1       1 = write (writeback), 0 = read (allocate)
//  d_wr_data      in   DATA_W  D-cache write data
//  d_req_data     out  DATA_W  read data to D-cache, valid while d_req_ready=1
//  d_req_ready    out  1       one-cycle completion pulse to D-cache
//  mem_req_addr   out  ADDR_W  memory address
//  mem_wr_data    out  DATA_W  memory write data
//  mem_req_valid  out  1       memory request, held until mem_req_ready
//  mem_req_wr     out  1       memory write enable
//  mem_req_data   in   DATA_W  memory read data, sampled when mem_req_ready=1
//  mem_req_ready  in   1       memory completion, one cycle
//  owner          out  2       2'b00 none, 2'b01 I-cache, 2'b10 D-cache
// BEHAVIOUR
//  - All outputs registered; reset (async, rst=1) clears every output to 0, state to IDLE, last_owner to I.
//  - FSM states: IDLE, BUSY, DONE.
//  - IDLE: if any valid, pick winner (see CONFIGURATION); next edge latches addr/wr/wdata into mem_req_*, mem_req_valid<=1, owner set, -> BUSY.
//    I-cache winner always forces mem_req_wr=0, mem_wr_data=0.
//  - BUSY: mem_req_* stable. On mem_req_ready=1: mem_req_valid<=0, owner's *_req_data<=mem_req_data (0 for writes),
//    owner's *_req_ready<=1, last_owner<=owner, -> DONE.
//  - DONE: exactly one cycle; ready pulse visible here; both valids ignored (requester drops valid this cycle); ready<=0, owner<=0, -> IDLE.
//  - Latency: valid seen at edge N -> mem_req_valid high after N; memory ready at edge M -> requester ready high after M;
//    minimum 1-cycle memory gives 3 cycles request-to-ready, 4 cycles back-to-back.
//  - Non-owner's ready never asserts; its valid just waits. Requester changing addr while waiting is harmless until granted.
//  - mem_req_ready while IDLE or DONE is ignored.
//  - Valid dropped by owner while BUSY: transaction still completes; ready pulse still issued.
//  - Reset mid-BUSY: mem_req_valid drops immediately, transaction abandoned, no ready pulse.
//  - *_req_data holds last value outside ready pulse (cleared only by reset).
// CONFIGURATION
//  - Macro ARB_ROUND_ROBIN_EN.
//  - Defined: on simultaneous i/d valid in IDLE, grant the side that is NOT last_owner (after reset D wins the first tie).
//  - Undefined: fixed priority, D-cache always wins ties; last_owner still tracked but unused for arbitration.
//  - Single requests are granted identically in both builds.
// TESTING
//  - Reset: assert rst mid-BUSY -> mem_req_valid, owner, both readies 0 same cycle; after release state IDLE, no ready pulse.
//  - I-only read 0x0000_0040, memory returns 0xDEAD_BEEF after 2 cycles -> mem_req_wr=0, i_req_data=0xDEAD_BEEF with one-cycle i_req_ready, d_req_ready=0.
//  - D write 0x0000_0100 data 0x1234_5678 -> mem_req_wr=1, mem_wr_data=0x1234_5678 held until mem_req_ready; d_req_ready pulse, d_req_data=0.
//  - Both valid in same cycle, both held, 1-cycle memory -> with ARB_ROUND_ROBIN_EN: D then I; without: D then I, and re-raised D beats waiting I.
//  - mem_req_ready pulsed in IDLE -> no state change, no ready pulses.
//  - 10 alternating back-to-back requests -> one mem_req_valid per transaction, DONE gap of 1 cycle, no request lost or duplicated.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between I-cache refills and D-cache refill/writeback, one transaction at a time.
// Build option ARB_ROUND_ROBIN_EN: alternate ties against the last owner; default build gives D-cache fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic              i_req_valid,
  output logic [DATA_W-1:0] i_req_data,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_valid,
  input  logic              d_req_wr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic [DATA_W-1:0] d_req_data,
  output logic              d_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_req_valid,
  output logic              mem_req_wr,
  input  logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_req_ready,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit ROUND_ROBIN = 1'b1;
`else
  localparam bit ROUND_ROBIN = 1'b0;
`endif

  state_t state;
  logic   last_d;   // last completed owner: 1 = D-cache, 0 = I-cache
  logic   grant_d;

  // D wins alone, or on a tie unless round-robin says it was served last
  always_comb begin
    grant_d = d_req_valid && (!i_req_valid || !ROUND_ROBIN || !last_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last_d        <= 1'b0;
      owner         <= OWN_NONE;
      mem_req_valid <= 1'b0;
      mem_req_wr    <= 1'b0;
      mem_req_addr  <= '0;
      mem_wr_data   <= '0;
      i_req_ready   <= 1'b0;
      i_req_data    <= '0;
      d_req_ready   <= 1'b0;
      d_req_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid || d_req_valid) begin
            mem_req_valid <= 1'b1;
            state         <= BUSY;
            if (grant_d) begin
              owner        <= OWN_D;
              mem_req_addr <= d_req_addr;
              mem_req_wr   <= d_req_wr;
              mem_wr_data  <= d_wr_data;
            end else begin
              owner        <= OWN_I;
              mem_req_addr <= i_req_addr;
              mem_req_wr   <= 1'b0;
              mem_wr_data  <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            last_d        <= (owner == OWN_D);
            state         <= DONE;
            if (owner == OWN_D) begin
              d_req_ready <= 1'b1;
              d_req_data  <= mem_req_wr ? '0 : mem_req_data;
            end else begin
              i_req_ready <= 1'b1;
              i_req_data  <= mem_req_data;
            end
          end
        end
        DONE: begin
          i_req_ready <= 1'b0;
          d_req_ready <= 1'b0;
          owner       <= OWN_NONE;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed cases, then two randomized requesters against a
// transaction-level arbitration/memory model; a negedge monitor checks every grant and ready pulse.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [1:0] S_I = 2'b01;
  localparam logic [1:0] S_D = 2'b10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] i_req_addr, d_req_addr, mem_req_addr;
  logic          i_req_valid, d_req_valid, d_req_wr;
  logic [DW-1:0] i_req_data, d_req_data, d_wr_data, mem_wr_data, mem_req_data;
  logic          i_req_ready, d_req_ready, mem_req_valid, mem_req_wr, mem_req_ready;
  logic [1:0]    owner;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_req_addr(i_req_addr), .i_req_valid(i_req_valid), .i_req_data(i_req_data), .i_req_ready(i_req_ready),
    .d_req_addr(d_req_addr), .d_req_valid(d_req_valid), .d_req_wr(d_req_wr), .d_wr_data(d_wr_data),
    .d_req_data(d_req_data), .d_req_ready(d_req_ready),
    .mem_req_addr(mem_req_addr), .mem_wr_data(mem_wr_data), .mem_req_valid(mem_req_valid),
    .mem_req_wr(mem_req_wr), .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
    .owner(owner)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- memory environment ----------------
  logic [31:0] store   [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  bit spur_en  = 1'b0;
  bit rand_lat = 1'b0;
  bit mem_hold = 1'b0;
  int fix_lat  = 0;

  initial begin : memory
    bit busy = 1'b0;
    int cnt  = 0;
    mem_req_ready = 1'b0;
    mem_req_data  = '0;
    forever begin
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      if (rst) begin
        busy = 1'b0;
      end else if (mem_req_valid && !mem_hold) begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = rand_lat ? int'($urandom_range(0, 3)) : fix_lat;
        end
        if (cnt == 0) begin
          mem_req_ready = 1'b1;
          if (mem_req_wr) begin
            mem_req_data = $urandom;
            store[mem_req_addr] = mem_wr_data;
          end else begin
            mem_req_data = store.exists(mem_req_addr) ? store[mem_req_addr] : init_word(mem_req_addr);
          end
          busy = 1'b0;
        end else begin
          cnt--;
        end
      end else if (!mem_req_valid && spur_en && $urandom_range(0, 5) == 0) begin
        mem_req_ready = 1'b1;
        mem_req_data  = $urandom;
      end
    end
  end

  // ---------------- reference model + monitor ----------------
  typedef struct { logic [1:0] side; logic [31:0] data; } resp_t;
  resp_t exp_q[$];
  int n_grant = 0;
  int n_ready = 0;

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  initial begin : monitor
    logic        pv_i = 1'b0, pv_d = 1'b0, pwr_d = 1'b0, prev_mv = 1'b0, prev_rdy = 1'b0, cur_wr = 1'b0;
    logic [31:0] pa_i = '0, pa_d = '0, pw_d = '0, cur_addr = '0, cur_wdata = '0, rdata;
    logic [1:0]  cur_side = 2'b00, model_last = S_I, win;
    resp_t       r;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        model_last = S_I;
        {pv_i, pv_d, prev_mv, prev_rdy} = '0;
      end else begin
        if (mem_req_valid && !prev_mv) begin
          // a new transaction was granted at the last edge from the inputs seen at the previous negedge
          n_grant++;
          chk("grant_has_request", {63'd0, pv_i | pv_d}, 64'd1);
          if (pv_i && pv_d) win = (RR && model_last == S_D) ? S_I : S_D;
          else              win = pv_d ? S_D : S_I;
          chk("grant_owner", {62'd0, owner}, {62'd0, win});
          if (win == S_D) begin
            cur_addr = pa_d; cur_wr = pwr_d; cur_wdata = pw_d;
          end else begin
            cur_addr = pa_i; cur_wr = 1'b0; cur_wdata = '0;
          end
          rdata = cur_wr ? 32'd0 : ref_get(cur_addr);
          if (cur_wr) ref_mem[cur_addr] = cur_wdata;
          exp_q.push_back('{win, rdata});
          model_last = win;
          cur_side   = win;
        end
        if (mem_req_valid) begin
          chk("mem_addr", {32'd0, mem_req_addr}, {32'd0, cur_addr});
          chk("mem_wr", {63'd0, mem_req_wr}, {63'd0, cur_wr});
          chk("mem_wr_data", {32'd0, mem_wr_data}, {32'd0, cur_wdata});
          chk("busy_owner", {62'd0, owner}, {62'd0, cur_side});
        end
        if (i_req_ready || d_req_ready) begin
          n_ready++;
          chk("one_ready", {63'd0, i_req_ready & d_req_ready}, 64'd0);
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_ready: i_ready=%0b d_ready=%0b with no transaction outstanding", i_req_ready, d_req_ready);
          end else begin
            r = exp_q.pop_front();
            chk("ready_side", {62'd0, d_req_ready, i_req_ready}, {62'd0, r.side});
            chk("ready_data", {32'd0, d_req_ready ? d_req_data : i_req_data}, {32'd0, r.data});
          end
        end
        if (prev_rdy)
          chk("done_exit", {59'd0, mem_req_valid, owner, i_req_ready, d_req_ready}, 64'd0);
        prev_mv  = mem_req_valid;
        prev_rdy = i_req_ready | d_req_ready;
        pv_i = i_req_valid; pa_i = i_req_addr;
        pv_d = d_req_valid; pa_d = d_req_addr; pwr_d = d_req_wr; pw_d = d_wr_data;
      end
    end
  end

  // ---------------- requesters (entered at posedge+1) ----------------
  task automatic i_request(input logic [31:0] a, output logic [31:0] rd, output int done_cyc);
    bit got = 1'b0;
    rd = '0; done_cyc = -1;
    i_req_addr = a; i_req_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (i_req_ready) begin got = 1'b1; rd = i_req_data; done_cyc = cyc; break; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL i_timeout: no i_req_ready for addr %0h", a);
    end
    @(posedge clk); #1;
    i_req_valid = 1'b0; i_req_addr = $urandom;
  endtask

  task automatic d_request(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                           output logic [31:0] rd, output int done_cyc);
    bit got = 1'b0;
    rd = '0; done_cyc = -1;
    d_req_addr = a; d_req_wr = wr; d_wr_data = wd; d_req_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (d_req_ready) begin got = 1'b1; rd = d_req_data; done_cyc = cyc; break; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL d_timeout: no d_req_ready for addr %0h", a);
    end
    @(posedge clk); #1;
    d_req_valid = 1'b0; d_req_addr = $urandom; d_req_wr = $urandom; d_wr_data = $urandom;
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 7)) << 2;
  endfunction

  logic [31:0] rd_a, rd_b;
  int t_a, t_b, t_c, g0, r0;

  initial begin : stim
    i_req_valid = 1'b0; i_req_addr = '0;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_wr = 1'b0; d_wr_data = '0;
    store[32'h40]   = 32'hDEAD_BEEF;
    ref_mem[32'h40] = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {58'd0, mem_req_valid, mem_req_wr, owner, i_req_ready, d_req_ready}, 64'd0);
    chk("rst_data", {i_req_data, d_req_data}, 64'd0);
    chk("rst_mem", {mem_req_addr, mem_wr_data}, 64'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // memory ready pulses while idle must be ignored
    spur_en = 1'b1; g0 = n_grant; r0 = n_ready;
    repeat (16) begin @(posedge clk); #1; end
    spur_en = 1'b0;
    @(negedge clk);
    chk("idle_state", {61'd0, mem_req_valid, owner}, 64'd0);
    chk("idle_no_grant", 64'(n_grant - g0), 64'd0);
    chk("idle_no_ready", 64'(n_ready - r0), 64'd0);
    @(posedge clk); #1;

    // I-only read, memory answers two cycles after the grant
    fix_lat = 1;
    i_request(32'h0000_0040, rd_a, t_a);
    chk("i_read_data", {32'd0, rd_a}, {32'd0, 32'hDEAD_BEEF});

    // D writeback, then read it back
    d_request(32'h0000_0100, 1'b1, 32'h1234_5678, rd_a, t_a);
    chk("d_write_data", {32'd0, rd_a}, 64'd0);
    d_request(32'h0000_0100, 1'b0, 32'hFFFF_FFFF, rd_a, t_a);
    chk("d_readback", {32'd0, rd_a}, {32'd0, 32'h1234_5678});

    // reset while BUSY abandons the transaction
    mem_hold = 1'b1;
    i_req_addr = 32'h80; i_req_valid = 1'b1;
    for (int k = 0; k < 20 && !mem_req_valid; k++) @(negedge clk);
    chk("rst_test_busy", {63'd0, mem_req_valid}, 64'd1);
    #2 rst = 1'b1;
    #1 chk("rst_busy_ctrl", {59'd0, mem_req_valid, owner, i_req_ready, d_req_ready}, 64'd0);
    i_req_valid = 1'b0;
    @(negedge clk); #1 rst = 1'b0;
    mem_hold = 1'b0; r0 = n_ready;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("rst_no_pulse", 64'(n_ready - r0), 64'd0);
    chk("rst_idle", {61'd0, mem_req_valid, owner}, 64'd0);
    @(posedge clk); #1;

    // simultaneous requests, D re-raised back-to-back while I waits
    fix_lat = 0;
    fork
      begin
        d_request(32'h8, 1'b0, 32'h0, rd_a, t_a);
        d_request(32'hC, 1'b1, 32'hCAFE_0001, rd_a, t_b);
      end
      i_request(32'h4, rd_b, t_c);
    join
    if (RR) chk("tie_order_rr", {62'd0, t_a < t_c, t_c < t_b}, 64'd3);
    else    chk("tie_order_fixed", {62'd0, t_a < t_b, t_b < t_c}, 64'd3);

    // ten alternating back-to-back transactions
    g0 = n_grant; r0 = n_ready;
    for (int n = 0; n < 10; n++) begin
      if (n % 2 == 0) i_request(rand_addr(), rd_a, t_a);
      else            d_request(rand_addr(), 1'($urandom), $urandom, rd_a, t_a);
    end
    chk("b2b_grants", 64'(n_grant - g0), 64'd10);
    chk("b2b_readies", 64'(n_ready - r0), 64'd10);

    // randomized concurrent traffic
    spur_en = 1'b1; rand_lat = 1'b1;
    g0 = n_grant;
    fork
      begin : rand_i
        logic [31:0] rd_i;
        int t_i;
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          i_request(rand_addr(), rd_i, t_i);
        end
      end
      begin : rand_d
        logic [31:0] rd_d;
        int t_d;
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          d_request(rand_addr(), 1'($urandom), $urandom, rd_d, t_d);
        end
      end
    join
    spur_en = 1'b0;
    repeat (4) @(negedge clk);
    chk("rand_grants", 64'(n_grant - g0), 64'd80);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
